// File: rtl/apb_pkg.sv
// Shared types for the APB host bridge: FSM states, captured request and response.
package apb_pkg;

    localparam int APB_PADDR_W = 12;
    localparam int APB_DATA_W  = 32;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_e;

    typedef struct packed {
        logic                   we;
        logic [APB_PADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0]  wdata;
    } apb_req_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
    } apb_rsp_t;

    // A request is rejected locally when misaligned or outside the APB address window.
    function automatic logic is_local_err(input logic [31:0] addr, input int paddr_w);
        return (addr[1:0] != 2'b00) || ((addr >> paddr_w) != 32'd0);
    endfunction

endpackage

// File: rtl/apb_host_bridge.sv
// Single-outstanding host request/response port to APB3 master.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module apb_host_bridge
    import apb_pkg::*;
#(
    parameter int PADDR_W        = APB_PADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_we_i,
    input  logic [31:0]        req_addr_i,
    input  logic [DATA_W-1:0]  req_wdata_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [DATA_W-1:0]  rsp_rdata_o,
    output logic               rsp_err_o,
    output logic [PADDR_W-1:0] paddr_o,
    output logic               psel_o,
    output logic               penable_o,
    output logic               pwrite_o,
    output logic [DATA_W-1:0]  pwdata_o,
    input  logic [DATA_W-1:0]  prdata_i,
    input  logic               pready_i,
    input  logic               pslverr_i
);

    apb_state_e state_q, state_d;
    apb_req_t   req_q, req_d;
    apb_rsp_t   rsp_q, rsp_d;
    logic       ready_q;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rsp_d   = rsp_q;
`ifdef APB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_valid_i && ready_q) begin
                    req_d.we    = req_we_i;
                    req_d.addr  = req_addr_i[PADDR_W-1:0];
                    req_d.wdata = req_wdata_i;
                    if (is_local_err(req_addr_i, PADDR_W)) begin
                        rsp_d.rdata = '0;
                        rsp_d.err   = 1'b1;
                        state_d     = RESP;
                    end else begin
                        state_d = SETUP;
`ifdef APB_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // Read data is only returned for successful reads.
                if (pready_i) begin
                    rsp_d.err   = pslverr_i;
                    rsp_d.rdata = (req_q.we || pslverr_i) ? '0 : prdata_i;
                    state_d     = RESP;
                end
`ifdef APB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    rsp_d.err   = 1'b1;
                    rsp_d.rdata = '0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready is registered so that every output reads 0 while reset is asserted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= '0;
            rsp_q   <= '0;
            ready_q <= 1'b0;
`ifdef APB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rsp_q   <= rsp_d;
            ready_q <= (state_d == IDLE);
`ifdef APB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign req_ready_o = ready_q;
    assign psel_o      = (state_q == SETUP) || (state_q == ACCESS);
    assign penable_o   = (state_q == ACCESS);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_rdata_o = rsp_q.rdata;
    assign rsp_err_o   = rsp_q.err;
    assign paddr_o     = req_q.addr;
    assign pwrite_o    = req_q.we;
    assign pwdata_o    = req_q.wdata;

endmodule

// File: tb/tb_apb_host_bridge.sv
// Self-checking bench for apb_host_bridge: a transaction-timeline model checked every cycle,
// plus literal latency/data expectations. Covers the APB_TIMEOUT_EN build as well.
module tb_apb_host_bridge;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid_i, req_we_i, rsp_ready_i;
   logic [31:0] req_addr_i, req_wdata_i;
   logic        req_ready_o, rsp_valid_o, rsp_err_o;
   logic [31:0] rsp_rdata_o;
   logic [11:0] paddr_o;
   logic        psel_o, penable_o, pwrite_o;
   logic [31:0] pwdata_o;
   logic [31:0] prdata = '0;
   logic        pready = 1'b0;
   logic        pslverr = 1'b0;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int pselCnt = 0;
   bit checkEn = 1'b0;

   bit          mValid = 1'b0;
   bit          mLocal, mWe, mErr;
   int          mAcc, mWaits, mHold;
   logic [31:0] mAddr, mWdata, mRdata;

   int          sWaits = 0;
   int          sCnt = 0;
   logic [31:0] sData = '0;
   bit          sErr = 1'b0;

   int          lat;
   logic [31:0] rd;
   bit          er;
   int          p0;

   apb_host_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
      .pwdata_o(pwdata_o), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
   );

   // Clock and a cycle index: during cycle k the counter reads k.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic reportFail(input string name);
      total++;
      bad++;
      $display("[TB] FAIL %s: bound expired at cycle %0d", name, cyc);
   endtask

   // APB slave: inserts sWaits wait states, then completes with sData/sErr.
   always @(negedge clk) begin
      if (psel_o && penable_o) begin
         pready  = (sCnt == sWaits);
         pslverr = sErr && (sCnt == sWaits);
         prdata  = sData;
         sCnt++;
      end else begin
         pready  = 1'b0;
         pslverr = 1'b0;
         prdata  = '0;
         sCnt    = 0;
      end
   end

   // Compare every cycle against the timeline implied by the last accepted request.
   always @(posedge clk) begin
      bit ePsel, ePen, eRsp, eRdy;
      int rspStart, rspEnd;
      #1;
      if (psel_o) pselCnt++;
      if (checkEn) begin
         ePsel = 1'b0; ePen = 1'b0; eRsp = 1'b0; eRdy = 1'b1;
         if (mValid) begin
            rspStart = mLocal ? mAcc + 1 : mAcc + 3 + mWaits;
            rspEnd   = rspStart + mHold;
            ePsel = !mLocal && cyc >= mAcc + 1 && cyc <= mAcc + 2 + mWaits;
            ePen  = !mLocal && cyc >= mAcc + 2 && cyc <= mAcc + 2 + mWaits;
            eRsp  = cyc >= rspStart && cyc <= rspEnd;
            eRdy  = !(cyc >= mAcc + 1 && cyc <= rspEnd);
         end
         checkOutput("psel", psel_o, ePsel);
         checkOutput("penable", penable_o, ePen);
         checkOutput("rsp_valid", rsp_valid_o, eRsp);
         checkOutput("req_ready", req_ready_o, eRdy);
         if (ePsel) begin
            checkOutput("paddr", {20'h0, paddr_o}, mAddr & 32'hFFF);
            checkOutput("pwrite", pwrite_o, mWe);
            if (mWe) checkOutput("pwdata", pwdata_o, mWdata);
         end
         if (eRsp) begin
            checkOutput("rsp_rdata", rsp_rdata_o, mRdata);
            checkOutput("rsp_err", rsp_err_o, mErr);
         end
      end
   end

   task automatic startReq(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input logic [31:0] rdata, input bit slverr,
                           input int hold);
      bit loc;
      int n;
      @(negedge clk);
      loc = (addr[1:0] != 2'b00) || (addr[31:12] != 20'h0);
      sWaits = waits; sData = rdata; sErr = slverr;
      req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_wdata_i = wdata;
      n = 0;
      while (!req_ready_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready_o) reportFail("accept");
      mValid = 1'b1; mAcc = cyc; mLocal = loc; mWe = we; mAddr = addr; mWdata = wdata;
      mHold = hold; mWaits = waits;
      mErr   = loc || slverr;
      mRdata = (loc || slverr || we) ? 32'h0 : rdata;
`ifdef APB_TIMEOUT_EN
      if (!loc && waits >= TMO) begin
         mWaits = TMO - 1;
         mErr   = 1'b1;
         mRdata = 32'h0;
      end
`endif
      @(negedge clk);
      req_valid_i = 1'b0;
   endtask

   task automatic finishRsp(output int l, output logic [31:0] d, output bit e);
      int n;
      n = 0;
      l = -1; d = 'x; e = 1'bx;
      while (!rsp_valid_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!rsp_valid_o) begin
         reportFail("response");
      end else begin
         l = cyc - mAcc;
         d = rsp_rdata_o;
         e = rsp_err_o;
         repeat (mHold) @(negedge clk);
         rsp_ready_i = 1'b1;
         @(negedge clk);
         rsp_ready_i = 1'b0;
      end
   endtask

   task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                input int waits, input logic [31:0] rdata, input bit slverr,
                                input int hold, output int l, output logic [31:0] d, output bit e);
      startReq(we, addr, wdata, waits, rdata, slverr, hold);
      finishRsp(l, d, e);
   endtask

   task automatic resetMidAccess();
      checkEn = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_psel", psel_o, 0);
      checkOutput("rst_mid_penable", penable_o, 0);
      checkOutput("rst_mid_rsp_valid", rsp_valid_o, 0);
      mValid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkEn = 1'b1;
   endtask

   // Main directed sequence.
   initial begin
      rst_n = 1'b0;
      req_valid_i = 1'b0; req_we_i = 1'b0; rsp_ready_i = 1'b0;
      req_addr_i = '0; req_wdata_i = '0;
      repeat (2) @(negedge clk);
      checkOutput("rst_psel", psel_o, 0);
      checkOutput("rst_penable", penable_o, 0);
      checkOutput("rst_rsp_valid", rsp_valid_o, 0);
      checkOutput("rst_req_ready", req_ready_o, 0);
      checkOutput("rst_rdata", rsp_rdata_o, 0);
      checkOutput("rst_err", rsp_err_o, 0);
      rst_n = 1'b1;
      @(negedge clk);
      checkEn = 1'b1;

      applyStimulus(1'b1, 32'h0000_0004, 32'h0000_00A5, 0, 32'h0, 1'b0, 0, lat, rd, er);
      checkOutput("wr_latency", lat, 3);
      checkOutput("wr_err", er, 0);
      checkOutput("wr_rdata", rd, 0);

      applyStimulus(1'b0, 32'h0000_0010, 32'h0, 3, 32'h1234_5678, 1'b0, 0, lat, rd, er);
      checkOutput("rd_latency", lat, 6);
      checkOutput("rd_rdata", rd, 32'h1234_5678);
      checkOutput("rd_err", er, 0);

      p0 = pselCnt;
      applyStimulus(1'b0, 32'h0000_0013, 32'h0, 0, 32'hFFFF_FFFF, 1'b0, 0, lat, rd, er);
      checkOutput("misalign_latency", lat, 1);
      checkOutput("misalign_err", er, 1);
      checkOutput("misalign_rdata", rd, 0);
      applyStimulus(1'b0, 32'h0000_1000, 32'h0, 0, 32'hFFFF_FFFF, 1'b0, 0, lat, rd, er);
      checkOutput("decode_latency", lat, 1);
      checkOutput("decode_err", er, 1);
      checkOutput("local_no_psel", pselCnt - p0, 0);

      applyStimulus(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1, 32'h0, 1'b1, 5, lat, rd, er);
      checkOutput("slverr_latency", lat, 4);
      checkOutput("slverr_err", er, 1);

      applyStimulus(1'b0, 32'h0000_0FFC, 32'h0, 2, 32'h0BAD_F00D, 1'b0, 1, lat, rd, er);
      checkOutput("top_addr_rdata", rd, 32'h0BAD_F00D);
      applyStimulus(1'b1, 32'h0000_0800, 32'h5555_AAAA, 0, 32'h0, 1'b0, 0, lat, rd, er);
      checkOutput("b2b_wr_latency", lat, 3);

`ifdef APB_TIMEOUT_EN
      applyStimulus(1'b0, 32'h0000_0008, 32'h0, 1000, 32'h55, 1'b0, 0, lat, rd, er);
      checkOutput("timeout_latency", lat, 3 + TMO - 1);
      checkOutput("timeout_err", er, 1);
      checkOutput("timeout_rdata", rd, 0);
      applyStimulus(1'b0, 32'h0000_000C, 32'h0, TMO - 1, 32'h77, 1'b0, 0, lat, rd, er);
      checkOutput("limit_ready_err", er, 0);
      checkOutput("limit_ready_rdata", rd, 32'h77);
      startReq(1'b0, 32'h0000_0030, 32'h0, 5, 32'h99, 1'b0, 0);
      @(negedge clk);
      checkOutput("pre_reset_penable", penable_o, 1);
`else
      startReq(1'b0, 32'h0000_0008, 32'h0, 100000, 32'h55, 1'b0, 0);
      repeat (1000) @(negedge clk);
      checkOutput("stuck_penable", penable_o, 1);
      checkOutput("stuck_rsp_valid", rsp_valid_o, 0);
`endif
      resetMidAccess();

      applyStimulus(1'b0, 32'h0000_0020, 32'h0, 1, 32'hCAFE_F00D, 1'b0, 0, lat, rd, er);
      checkOutput("post_reset_latency", lat, 4);
      checkOutput("post_reset_rdata", rd, 32'hCAFE_F00D);
      checkOutput("post_reset_err", er, 0);

      repeat (3) @(negedge clk);
      checkEn = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog so a hung DUT still ends the run.
   initial begin
      #500000;
      bad++;
      $display("[TB] FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
